// File: rtl/gda_err_recovery_n8_if.sv
// Handshake and status bundle for the GDA error-recovery stage.
// The slave modport is the stage's view and the master modport is the driver's view.
interface gda_err_recovery_n8_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in1;
  logic [7:0]       in2;
  logic [8:0]       approx_res;
  logic             recover_en;
  logic             out_valid;
  logic             out_ready;
  logic [8:0]       out_res;
  logic             out_err;
  logic             cnt_clr;
  logic [CNT_W-1:0] err_cnt;

  modport slave (
    input  in_valid, in1, in2, approx_res, recover_en, out_ready, cnt_clr,
    output in_ready, out_valid, out_res, out_err, err_cnt
  );

  modport master (
    output in_valid, in1, in2, approx_res, recover_en, out_ready, cnt_clr,
    input  in_ready, out_valid, out_res, out_err, err_cnt
  );
endinterface

// File: rtl/gda_err_recovery_n8.sv
// Error detection and recovery stage for the 8-bit GDA approximate adder.
// The adder can only miss the speculative carry into bit 6. That happens when a
// carry generated in bits [1:0] propagates through bits [5:2]. A clean sum is
// forwarded after the CHECK cycle. A faulty sum is repaired in FIX by adding 1
// to bits [8:6], or it is forwarded unchanged with out_err set.
module gda_err_recovery_n8 #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gda_err_recovery_n8_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_FIX   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // Only operand bits [5:0] take part in the bit-6 carry check, so only they are kept.
  logic [5:0]       r_a;
  logic [5:0]       r_b;
  logic [8:0]       r_approx;
  logic             r_rec;
  logic [8:0]       r_out_res;
  logic             r_out_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [5:0]       w_p;
  logic [5:0]       w_g;
  logic             w_c2;
  logic             w_err;
  logic [8:0]       w_fixed;
  logic             w_cnt_sat;

  assign w_in_ready = (r_state == S_IDLE) | ((r_state == S_OUT) & bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Carry into bit 2 from the low pair, then full propagation through bits [5:2].
  assign w_p   = r_a ^ r_b;
  assign w_g   = r_a & r_b;
  assign w_c2  = w_g[1] | (w_p[1] & w_g[0]);
  assign w_err = (&w_p[5:2]) & w_c2;

  // The missed carry is restored on the upper three bits. The low six bits are already exact.
  assign w_fixed = {r_approx[8:6] + 3'd1, r_approx[5:0]};

  assign w_cnt_sat = &r_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_err && r_rec) begin
          w_state_next = S_FIX;
        end else begin
          w_state_next = S_OUT;
        end
      end
      S_FIX: begin
        w_state_next = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          w_state_next = w_accept ? S_CHECK : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Capture the operand/result triple and the recovery mode on accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_approx <= '0;
      r_rec    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.in1[5:0];
      r_b      <= bus.in2[5:0];
      r_approx <= bus.approx_res;
      r_rec    <= bus.recover_en;
    end
  end

  // Result registers: loaded in CHECK (pass-through) or FIX (corrected), held otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_res <= '0;
      r_out_err <= 1'b0;
    end else if (r_state == S_CHECK) begin
      if (!(w_err && r_rec)) begin
        r_out_res <= r_approx;
        r_out_err <= w_err;
      end
    end else if (r_state == S_FIX) begin
      r_out_res <= w_fixed;
      r_out_err <= 1'b1;
    end
  end

  // Saturating error counter. A clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
    end else if ((r_state == S_CHECK) && w_err && !w_cnt_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_res   = r_out_res;
  assign bus.out_err   = r_out_err;
  assign bus.err_cnt   = r_cnt;

endmodule
